// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   sched_state_e - FSM state encoding
//   HDR_MARK      - upper nibble of every channel-ID header byte
//   hdr_byte()    - builds the {mark, id} header byte for a requester index
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_DATA    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } sched_state_e;

    localparam logic [3:0] HDR_MARK = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_MARK, id};
    endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// rr_arbiter
// Combinational round-robin arbiter: picks the first asserted request
// strictly after ptr, wrapping around, so ptr itself has lowest priority.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [IW-1:0] index of the previous winner
//   gnt   [N-1:0]  one-hot winner (0 when no request)
//   idx   [IW-1:0] binary index of the winner
//   found          some request was asserted
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART transmitter among NUM_REQ byte-stream requesters. A
// requester owns the UART for a whole packet (optionally prefixed by a
// {A, id} header byte); each byte goes through the UART start/busy handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_byte/req_last  per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                one-cycle accept pulse per requester
//   grant                    one-hot current owner, 0 when idle
//   uart_transmit/uart_tx_byte   start pulse and byte to the UART
//   uart_is_transmitting     UART busy
//   busy                     scheduler not idle
//   tx_timeout               UART never acknowledged a start pulse
//   pkt_trunc                grant released at MAX_PKT without req_last
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int HEADER_EN     = 1,
    parameter int MAX_PKT       = 64,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic                 busy,
    output logic                 tx_timeout,
    output logic                 pkt_trunc
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT);
    // The timeout pulse is registered and WAIT_HI starts one cycle after the
    // start pulse, so the counter fires two counts early to land the pulse
    // exactly START_TIMEOUT cycles after uart_transmit.
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 2);
    localparam logic [7:0]    CNT_MAX  = 8'(MAX_PKT);

    sched_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 hdr_q, hdr_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 uart_transmit_q, uart_transmit_d;
    logic [7:0]           uart_tx_byte_q, uart_tx_byte_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_timeout_q, tx_timeout_d;
    logic                 pkt_trunc_q, pkt_trunc_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_found;
    logic                 do_send;
    logic [IW-1:0]        send_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Next-state logic. A send is registered on the transition into the
    // cycle where it is visible, so the start pulse, req_ready and the byte
    // appear together one cycle after the decision; DATA then sees its own
    // pulse in uart_transmit_q and moves on without resampling the requester.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        idx_d           = idx_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        last_d          = last_q;
        hdr_d           = hdr_q;
        tmo_d           = '0;
        uart_transmit_d = 1'b0;
        uart_tx_byte_d  = uart_tx_byte_q;
        req_ready_d     = '0;
        tx_timeout_d    = 1'b0;
        pkt_trunc_d     = 1'b0;
        do_send         = 1'b0;
        send_idx        = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_found && !uart_is_transmitting) begin
                    grant_d = arb_gnt;
                    idx_d   = arb_idx;
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    if (HEADER_EN != 0) begin
                        state_d         = ST_HDR;
                        hdr_d           = 1'b1;
                        uart_transmit_d = 1'b1;
                        uart_tx_byte_d  = hdr_byte(4'(arb_idx));
                    end else begin
                        state_d  = ST_DATA;
                        hdr_d    = 1'b0;
                        do_send  = 1'b1;
                        send_idx = arb_idx;
                    end
                end
            end
            ST_HDR: begin
                state_d = ST_WAIT_HI;
            end
            ST_DATA: begin
                if (uart_transmit_q) begin
                    state_d = ST_WAIT_HI;
                end else if (req_valid[idx_q] && !uart_is_transmitting) begin
                    do_send = 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (uart_is_transmitting) begin
                    state_d = ST_WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    tx_timeout_d = 1'b1;
                    grant_d      = '0;
                    hdr_d        = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!uart_is_transmitting) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = ST_DATA;
                        do_send = req_valid[idx_q];
                    end else if (last_q) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        pkt_trunc_d = 1'b1;
                        grant_d     = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        do_send = req_valid[idx_q];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (do_send) begin
            uart_transmit_d = 1'b1;
            uart_tx_byte_d  = req_byte[{send_idx, 3'b000} +: 8];
            req_ready_d     = NUM_REQ'(1) << send_idx;
            last_d          = req_last[send_idx];
            cnt_d           = cnt_d + 8'd1;
        end
    end

    // State and output registers; reset puts the pointer on the last
    // requester so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            idx_q           <= '0;
            ptr_q           <= IW'(NUM_REQ - 1);
            cnt_q           <= '0;
            last_q          <= 1'b0;
            hdr_q           <= 1'b0;
            tmo_q           <= '0;
            uart_transmit_q <= 1'b0;
            uart_tx_byte_q  <= '0;
            req_ready_q     <= '0;
            tx_timeout_q    <= 1'b0;
            pkt_trunc_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            idx_q           <= idx_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            last_q          <= last_d;
            hdr_q           <= hdr_d;
            tmo_q           <= tmo_d;
            uart_transmit_q <= uart_transmit_d;
            uart_tx_byte_q  <= uart_tx_byte_d;
            req_ready_q     <= req_ready_d;
            tx_timeout_q    <= tx_timeout_d;
            pkt_trunc_q     <= pkt_trunc_d;
        end
    end

    assign grant         = grant_q;
    assign req_ready     = req_ready_q;
    assign uart_transmit = uart_transmit_q;
    assign uart_tx_byte  = uart_tx_byte_q;
    assign tx_timeout    = tx_timeout_q;
    assign pkt_trunc     = pkt_trunc_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Directed bench for uart_tx_sched with 4 requesters, header enabled,
// MAX_PKT=4 and START_TIMEOUT=16. A UART model holds busy for 10 cycles per
// start pulse (or never, when uart_dead is set). Requesters are byte queues
// presented on req_* and popped on req_ready.
module tb_uart_tx_sched;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_byte = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            uart_transmit;
    logic [7:0]      uart_tx_byte;
    logic            uart_is_transmitting;
    logic            busy;
    logic            tx_timeout;
    logic            pkt_trunc;

    int  busy_cnt = 0;
    bit  uart_dead = 1'b0;

    logic [8:0]    mem [NR][16];
    int            head [NR];
    int            tail [NR];
    bit            pause [NR];
    int            ready_cnt [NR];

    logic [7:0]    log_byte [64];
    logic [NR-1:0] log_gnt [64];
    int            log_cyc [64];
    int            log_n;

    int            cycle = 0;
    int            trunc_n, trunc_cyc, timeout_n, timeout_cyc, overlap_n;
    logic [NR-1:0] trunc_gnt, timeout_gnt;
    int            tests_run = 0;
    int            tests_failed = 0;

    uart_tx_sched #(
        .NUM_REQ(NR), .HEADER_EN(1), .MAX_PKT(4), .START_TIMEOUT(16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_byte             (req_byte),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .grant                (grant),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .busy                 (busy),
        .tx_timeout           (tx_timeout),
        .pkt_trunc            (pkt_trunc)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles after each start pulse, unaffected by
    // the scheduler reset.
    assign uart_is_transmitting = (busy_cnt != 0);
    always @(posedge clk) begin
        if (uart_transmit && !uart_dead) busy_cnt <= 10;
        else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
    end

    task automatic refresh_req();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i] && !pause[i]) begin
                req_valid[i]        = 1'b1;
                req_byte[8*i +: 8]  = mem[i][head[i]][7:0];
                req_last[i]         = mem[i][head[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_byte[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic l);
        mem[i][tail[i]] = {l, b};
        tail[i]++;
        refresh_req();
    endtask

    // One cycle: sample DUT outputs on the falling edge, log events and pop
    // accepted bytes.
    task automatic tick();
        @(negedge clk);
        cycle++;
        if (uart_transmit) begin
            if (log_n < 64) begin
                log_byte[log_n] = uart_tx_byte;
                log_gnt[log_n]  = grant;
                log_cyc[log_n]  = cycle;
            end
            log_n++;
            if (uart_is_transmitting) overlap_n++;
        end
        if (tx_timeout) begin timeout_n++; timeout_cyc = cycle; timeout_gnt = grant; end
        if (pkt_trunc)  begin trunc_n++;   trunc_cyc = cycle;   trunc_gnt = grant;   end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin head[i]++; ready_cnt[i]++; end
        end
        refresh_req();
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0; tail[i] = 0; pause[i] = 1'b0; ready_cnt[i] = 0;
        end
        for (int k = 0; k < 64; k++) begin
            log_byte[k] = '0; log_gnt[k] = '0; log_cyc[k] = 0;
        end
        log_n = 0; trunc_n = 0; trunc_cyc = 0; timeout_n = 0; timeout_cyc = 0;
        overlap_n = 0; trunc_gnt = '0; timeout_gnt = '0;
        refresh_req();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        uart_dead = 1'b0;
        clear_tb();
        repeat (12) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        bit pending;
        n = 0;
        pending = |req_valid;
        while ((busy || pending) && n < limit) begin
            tick();
            n++;
            pending = |req_valid;
        end
        tests_run++;
        if (n >= limit) begin
            tests_failed++;
            $display("[TB] FAIL %s_idle: still busy=%b after %0d cycles, required idle", name, busy, n);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        clear_tb();
        tick(); tick();
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_grant_busy: got %b/%b required 0000/0", grant, busy);
        end
        tests_run++;
        if ({uart_transmit, uart_tx_byte} !== 9'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_uart: got %b/%h required 0/00", uart_transmit, uart_tx_byte);
        end
        tests_run++;
        if ({req_ready, tx_timeout, pkt_trunc} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pulses: got %b required 000000", {req_ready, tx_timeout, pkt_trunc});
        end
        rst = 1'b1;
        repeat (5) tick();
        tests_run++;
        if (busy !== 1'b0 || grant !== 4'b0000 || log_n != 0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_req: busy=%b grant=%b sends=%0d required 0/0000/0", busy, grant, log_n);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4];
        int t0;
        exp_b = '{8'hA0, 8'h00, 8'h80, 8'h0F};
        do_reset();
        push(0, 8'h00, 1'b0);
        push(0, 8'h80, 1'b0);
        push(0, 8'h0F, 1'b1);
        t0 = cycle;
        wait_idle("single", 200);
        tests_run++;
        if (log_n != 4) begin
            tests_failed++;
            $display("[TB] FAIL single_count: got %0d sends required 4", log_n);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (log_byte[k] !== exp_b[k] || log_gnt[k] !== 4'b0001) begin
                tests_failed++;
                $display("[TB] FAIL single_byte%0d: got %h/%b required %h/0001", k, log_byte[k], log_gnt[k], exp_b[k]);
            end
        end
        tests_run++;
        if (log_cyc[0] != t0 + 1) begin
            tests_failed++;
            $display("[TB] FAIL first_start_latency: got cycle %0d required %0d", log_cyc[0], t0 + 1);
        end
        tests_run++;
        if (log_cyc[1] - log_cyc[0] != 12) begin
            tests_failed++;
            $display("[TB] FAIL byte_gap: got %0d required 12", log_cyc[1] - log_cyc[0]);
        end
        tests_run++;
        if (ready_cnt[0] != 3 || grant !== 4'b0000 || overlap_n != 0) begin
            tests_failed++;
            $display("[TB] FAIL single_end: ready=%0d grant=%b overlap=%0d required 3/0000/0", ready_cnt[0], grant, overlap_n);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]    exp_b [12];
        logic [NR-1:0] exp_g [12];
        exp_b = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                  8'hA2, 8'h21, 8'h22, 8'hA0, 8'h03, 8'h04};
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                  4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        wait_idle("rr", 400);
        tests_run++;
        if (log_n != 12) begin
            tests_failed++;
            $display("[TB] FAIL rr_count: got %0d sends required 12", log_n);
        end
        for (int k = 0; k < 12; k++) begin
            tests_run++;
            if (log_byte[k] !== exp_b[k] || log_gnt[k] !== exp_g[k]) begin
                tests_failed++;
                $display("[TB] FAIL rr_byte%0d: got %h/%b required %h/%b", k, log_byte[k], log_gnt[k], exp_b[k], exp_g[k]);
            end
        end
        tests_run++;
        if (ready_cnt[0] != 4 || ready_cnt[1] != 2 || ready_cnt[2] != 2 || overlap_n != 0) begin
            tests_failed++;
            $display("[TB] FAIL rr_ready: got %0d,%0d,%0d overlap=%0d required 4,2,2 overlap=0",
                     ready_cnt[0], ready_cnt[1], ready_cnt[2], overlap_n);
        end
    endtask

    task automatic test_truncate();
        logic [7:0] exp_b [8];
        int n;
        exp_b = '{8'hA3, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA3, 8'h35, 8'h36};
        do_reset();
        for (int k = 0; k < 6; k++) push(3, 8'h31 + 8'(k), 1'b0);
        n = 0;
        while (log_n < 8 && n < 300) begin tick(); n++; end
        repeat (20) tick();
        tests_run++;
        if (log_n != 8) begin
            tests_failed++;
            $display("[TB] FAIL trunc_count: got %0d sends required 8", log_n);
        end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (log_byte[k] !== exp_b[k] || log_gnt[k] !== 4'b1000) begin
                tests_failed++;
                $display("[TB] FAIL trunc_byte%0d: got %h/%b required %h/1000", k, log_byte[k], log_gnt[k], exp_b[k]);
            end
        end
        tests_run++;
        if (trunc_n != 1 || trunc_cyc != log_cyc[4] + 12 || trunc_gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL trunc_pulse: got n=%0d cyc=%0d grant=%b required 1/%0d/0000",
                     trunc_n, trunc_cyc, trunc_gnt, log_cyc[4] + 12);
        end
        tests_run++;
        if (log_cyc[5] != trunc_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL trunc_regrant: got cycle %0d required %0d", log_cyc[5], trunc_cyc + 1);
        end
        tests_run++;
        if (grant !== 4'b1000 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL trunc_hold: got %b/%b required 1000/1", grant, busy);
        end
    endtask

    task automatic test_timeout();
        logic [7:0]    exp_b [5];
        logic [NR-1:0] exp_g [5];
        int n;
        exp_b = '{8'hA0, 8'hA1, 8'h51, 8'hA0, 8'h41};
        exp_g = '{4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
        do_reset();
        uart_dead = 1'b1;
        push(0, 8'h41, 1'b1);
        push(1, 8'h51, 1'b1);
        n = 0;
        while (timeout_n == 0 && n < 100) begin tick(); n++; end
        uart_dead = 1'b0;
        tests_run++;
        if (timeout_n != 1 || timeout_cyc != log_cyc[0] + 16 || timeout_gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_pulse: got n=%0d cyc=%0d grant=%b required 1/%0d/0000",
                     timeout_n, timeout_cyc, timeout_gnt, log_cyc[0] + 16);
        end
        wait_idle("timeout", 200);
        tests_run++;
        if (log_n != 5 || log_cyc[1] != timeout_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_next: got sends=%0d cyc=%0d required 5/%0d", log_n, log_cyc[1], timeout_cyc + 1);
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (log_byte[k] !== exp_b[k] || log_gnt[k] !== exp_g[k]) begin
                tests_failed++;
                $display("[TB] FAIL timeout_byte%0d: got %h/%b required %h/%b", k, log_byte[k], log_gnt[k], exp_b[k], exp_g[k]);
            end
        end
        tests_run++;
        if (ready_cnt[0] != 1 || ready_cnt[1] != 1 || timeout_n != 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ready: got %0d,%0d timeouts=%0d required 1,1,1", ready_cnt[0], ready_cnt[1], timeout_n);
        end
    endtask

    task automatic test_reset_mid();
        int n, p;
        do_reset();
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b1);
        n = 0;
        while (log_n < 1 && n < 20) begin tick(); n++; end
        p = log_cyc[0];
        repeat (3) tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0 || uart_tx_byte !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midrst_state: got %b/%b/%h required 0000/0/00", grant, busy, uart_tx_byte);
        end
        tests_run++;
        if ({uart_transmit, req_ready, tx_timeout, pkt_trunc} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pulses: got %b required 0000000", {uart_transmit, req_ready, tx_timeout, pkt_trunc});
        end
        tick();
        rst = 1'b1;
        n = 0;
        while (log_n < 2 && n < 40) begin tick(); n++; end
        tests_run++;
        if (log_cyc[1] != p + 12 || log_byte[1] !== 8'hA0 || overlap_n != 0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_restart: got cyc=%0d byte=%h overlap=%0d required %0d/a0/0",
                     log_cyc[1], log_byte[1], overlap_n, p + 12);
        end
        wait_idle("midrst", 200);
        tests_run++;
        if (log_n != 4 || log_byte[2] !== 8'h61 || log_byte[3] !== 8'h62 || ready_cnt[0] != 2) begin
            tests_failed++;
            $display("[TB] FAIL midrst_data: got sends=%0d %h %h ready=%0d required 4 61 62 2",
                     log_n, log_byte[2], log_byte[3], ready_cnt[0]);
        end
    endtask

    task automatic test_hold_grant();
        logic [7:0]    exp_b [6];
        logic [NR-1:0] exp_g [6];
        int n, bad;
        bit seen;
        exp_b = '{8'hA1, 8'h71, 8'h72, 8'h73, 8'hA2, 8'h81};
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        do_reset();
        push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
        push(2, 8'h81, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (req_ready[1]) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL hold_first_ready: got none in %0d cycles required one", n);
        end
        pause[1] = 1'b1;
        refresh_req();
        bad = 0;
        repeat (20) begin
            tick();
            if (grant !== 4'b0010) bad++;
        end
        tests_run++;
        if (bad != 0 || log_n != 2) begin
            tests_failed++;
            $display("[TB] FAIL hold_grant: got %0d lost cycles, %0d sends required 0, 2", bad, log_n);
        end
        pause[1] = 1'b0;
        refresh_req();
        wait_idle("hold", 300);
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (log_byte[k] !== exp_b[k] || log_gnt[k] !== exp_g[k]) begin
                tests_failed++;
                $display("[TB] FAIL hold_byte%0d: got %h/%b required %h/%b", k, log_byte[k], log_gnt[k], exp_b[k], exp_g[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_truncate();
        test_timeout();
        test_reset_mid();
        test_hold_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Sits between client logic and the UART transmit port (`transmit`, `tx_byte`, `is_transmitting`). It grants the UART to one requester for a whole packet, optionally prefixing a channel-ID header byte, and sequences each byte through the UART's start/busy handshake.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16
- `HEADER_EN`, 1: 1 = send header byte `{4'hA, id[3:0]}` before each packet
- `MAX_PKT`, 64: max data bytes per grant, 1..255
- `START_TIMEOUT`, 16: cycles to wait for `uart_is_transmitting` to rise after a start pulse
---
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_byte`
- `req_byte`  in  8*NUM_REQ  byte of requester i at `[8*i+7:8*i]`
- `req_last`  in  NUM_REQ  qualifies `req_byte`: last byte of the packet
- `req_ready`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle
- `uart_transmit`  out  1  one-cycle start pulse to the UART
- `uart_tx_byte`  out  8  byte to the UART, valid while `uart_transmit`=1
- `uart_is_transmitting`  in  1  UART busy
- `busy`  out  1  scheduler not in IDLE
- `tx_timeout`  out  1  one-cycle pulse: UART failed to start
- `pkt_trunc`  out  1  one-cycle pulse: grant released at `MAX_PKT` without `req_last`

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer `NUM_REQ-1`, so requester 0 wins first.
- Requester rule: `req_byte`/`req_last` are held stable while `req_valid`=1 until `req_ready`. Valid may drop between bytes.
- States: IDLE, HDR, DATA, WAIT_HI, WAIT_LO.
- IDLE: arbitrate only when some `req_valid` is set and `uart_is_transmitting`=0. The winner is the first valid index after the pointer, circularly.
  - Register `grant` and the pointer.
  - Go to HDR if `HEADER_EN`, else to DATA.
- HDR: pulse `uart_transmit` with `{4'hA, id}`, then go to WAIT_HI.
- DATA: wait while `req_valid[g]`=0; the grant stays held indefinitely.
  - When valid: pulse `uart_transmit` and `req_ready[g]` in the same cycle with `req_byte[g]`.
  - Latch `req_last`, increment the 8-bit data count, then go to WAIT_HI.
- WAIT_HI: go to WAIT_LO when `uart_is_transmitting`=1.
  - After `START_TIMEOUT` cycles without it: pulse `tx_timeout`, clear `grant`, go to IDLE and abandon the packet.
- WAIT_LO: when `uart_is_transmitting`=0, choose the next step:
  - Header just sent: go to DATA.
  - Latched last: clear `grant`, go to IDLE.
  - Count = `MAX_PKT`: pulse `pkt_trunc`, clear `grant`, go to IDLE.
  - Otherwise: go to DATA.
- Count resets to 0 on each new grant.
- A requester that drops `req_valid` mid-packet keeps the grant; other requesters starve until it finishes. This is the decided behaviour.
- Asynchronous reset mid-byte: everything returns to reset values immediately. The UART may still be transmitting; IDLE's `uart_is_transmitting`=0 guard prevents overlap.

## Timing
- The cycle IDLE sees a valid request is T.
  - T+1: `grant` is set and the state is HDR/DATA.
  - T+1: `uart_transmit`=1 for the first byte (header or data), provided `req_valid` holds.
- `uart_transmit` and `req_ready` are registered, exactly one cycle wide, and never asserted while `uart_is_transmitting`=1.
- Inter-byte gap: the next start pulse comes 1 cycle after `uart_is_transmitting` falls (WAIT_LO→DATA, pulse issued in DATA).
- Grant release: `grant`=0 the cycle after the falling edge of busy for the last byte. A new arbitration can start in that same IDLE cycle, so the next `grant` appears one cycle later.
- `busy`=1 in every state except IDLE.

## Structure
- A shared package holds:
  - state encoding constants;
  - header mark `4'hA`;
  - the `{mark,id}` header-byte helper function.
- Natural sub-module: `rr_arbiter`. It is combinational priority-after-pointer over `NUM_REQ`, returning a one-hot grant and index, and is reusable by the FIFO read side.
- Top holds the FSM, count, timeout counter and output registers.

## Test plan
- Single requester 0 sends 3 bytes 0x00,0x80,0x0F (last on 0x0F), `HEADER_EN`=1, UART model busy 10 cycles/byte.
  - UART sees 0xA0,0x00,0x80,0x0F.
  - `req_ready` pulses 3 times; `grant` returns to 0.
- Requesters 0,1,2 all valid with 2-byte packets.
  - Packet order 0,1,2, then 0 again if still valid.
  - Headers 0xA0,0xA1,0xA2; bytes never interleave.
- `MAX_PKT`=4, requester 3 streams 6 bytes without `req_last`.
  - `pkt_trunc` pulses after byte 4.
  - Re-granted with header 0xA3 for the remaining 2 bytes.
- UART model never raises busy.
  - `tx_timeout` pulses exactly 16 cycles after `uart_transmit`.
  - `grant`=0; the next requester is served.
- Assert `rst`=0 during WAIT_LO with the UART model still busy.
  - All outputs 0 immediately.
  - No `uart_transmit` until `uart_is_transmitting` falls.
- Requester 1 drops `req_valid` for 20 cycles mid-packet while requester 2 is valid.
  - `grant` stays on 1; requester 2 is served only after 1's last byte.
